// File: rtl/align_compactor.sv
// Drops per-row skip columns and trailing padding from the align stage's raster groups,
// then repacks the surviving items into dense groups for the write stage.
module align_compactor #(
    parameter int unsigned GROUP_SIZE   = 8,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned LOG_MAX_COLS = 16,
    parameter int unsigned LOG_MAX_ROWS = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             configure,
    input  logic [LOG_MAX_ROWS-1:0]          num_rows,
    input  logic [LOG_MAX_COLS-1:0]          skip_cols,
    input  logic [LOG_MAX_COLS-1:0]          keep_cols,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in,
    input  logic                             valid_in,
    output logic                             avail_out,
    output logic [GROUP_SIZE*DATA_WIDTH-1:0] data_out,
    output logic                             valid_out,
    input  logic                             avail_in
);

    localparam int unsigned GrpW = GROUP_SIZE * DATA_WIDTH;
    localparam int unsigned ClW  = LOG_MAX_COLS + 1;
    localparam int unsigned ColW = LOG_MAX_COLS + 2;  // col + lane offset never overflows
    localparam int unsigned RowW = LOG_MAX_ROWS + 1;
    localparam int unsigned IdxW = $clog2(2 * GROUP_SIZE);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e                                   state_q, state_d;
    logic [LOG_MAX_ROWS-1:0]                  num_rows_q, num_rows_d;
    logic [LOG_MAX_COLS-1:0]                  skip_q, skip_d;
    logic [ClW-1:0]                           row_len_q, row_len_d;
    logic [ClW-1:0]                           col_q, col_d;
    logic [RowW-1:0]                          row_q, row_d;
    logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0]    pend_q, pend_d;
    logic [IdxW-1:0]                          pend_cnt_q, pend_cnt_d;
    logic [GrpW-1:0]                          out_data_q, out_data_d;
    logic                                     out_valid_q, out_valid_d;

    logic [3:0][GrpW-1:0]                     fifo_q, fifo_d;
    logic [1:0]                               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]                               fifo_cnt_q, fifo_cnt_d;
    logic                                     fifo_full, fifo_almost_full, fifo_empty;
    logic                                     push, pop;
    logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0]    head;

    logic [2*GROUP_SIZE-1:0][DATA_WIDTH-1:0]  cat;
    logic [IdxW-1:0]                          total;
    logic [ColW-1:0]                          lane_c, col_sum;
    logic [RowW-1:0]                          lane_r, row_next;
    logic [ClW-1:0]                           col_next;
    logic                                     wrap, last_done;

    // Input FIFO
    always_comb begin
        fifo_full        = (fifo_cnt_q == 3'd4);
        fifo_almost_full = (fifo_cnt_q == 3'd3);
        fifo_empty       = (fifo_cnt_q == 3'd0);
        avail_out        = ~fifo_full & ~fifo_almost_full;
        push             = valid_in & ~fifo_full;
        head             = fifo_q[rd_ptr_q];
        fifo_d           = fifo_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        fifo_cnt_d       = fifo_cnt_q;
        if (push) begin
            fifo_d[wr_ptr_q] = data_in;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Classify the head group's lanes and append the kept ones after the pending items.
    always_comb begin
        cat                   = '0;
        cat[GROUP_SIZE-1:0]   = pend_q;
        total                 = pend_cnt_q;
        lane_c                = '0;
        lane_r                = '0;
        for (int i = 0; i < GROUP_SIZE; i++) begin
            lane_c = ColW'(col_q) + ColW'(i);
            lane_r = row_q;
            if (lane_c >= ColW'(row_len_q)) begin
                lane_c = lane_c - ColW'(row_len_q);
                lane_r = row_q + RowW'(1);
            end
            if ((lane_c >= ColW'(skip_q)) && (lane_r < RowW'(num_rows_q))) begin
                cat[total] = head[i];
                total      = total + IdxW'(1);
            end
        end
        col_sum   = ColW'(col_q) + ColW'(GROUP_SIZE);
        wrap      = (col_sum >= ColW'(row_len_q));
        col_next  = wrap ? ClW'(col_sum - ColW'(row_len_q)) : ClW'(col_sum);
        row_next  = row_q + RowW'(wrap);
        last_done = wrap && (row_next == RowW'(num_rows_q));
    end

    always_comb begin
        state_d     = state_q;
        num_rows_d  = num_rows_q;
        skip_d      = skip_q;
        row_len_d   = row_len_q;
        col_d       = col_q;
        row_d       = row_q;
        pend_d      = pend_q;
        pend_cnt_d  = pend_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        pop         = 1'b0;
        if (configure) begin
            num_rows_d = num_rows;
            skip_d     = skip_cols;
            row_len_d  = ClW'(skip_cols) + ClW'(keep_cols);
            col_d      = '0;
            row_d      = '0;
            pend_d     = '0;
            pend_cnt_d = '0;
            state_d    = StRun;
        end else begin
            unique case (state_q)
                StIdle: ;
                StRun: begin
                    if (!fifo_empty && avail_in) begin
                        pop   = 1'b1;
                        col_d = col_next;
                        row_d = row_next;
                        if (total >= IdxW'(GROUP_SIZE)) begin
                            out_valid_d = 1'b1;
                            out_data_d  = cat[GROUP_SIZE-1:0];
                            pend_d      = cat[2*GROUP_SIZE-1:GROUP_SIZE];
                            pend_cnt_d  = total - IdxW'(GROUP_SIZE);
                        end else begin
                            pend_d     = cat[GROUP_SIZE-1:0];
                            pend_cnt_d = total;
                        end
                        if (last_done) begin
                            state_d = (pend_cnt_d != '0) ? StFlush : StIdle;
                        end
                    end
                end
                StFlush: begin
                    // Unused pending lanes are already zero, giving the padded tail group.
                    if (avail_in) begin
                        out_valid_d = 1'b1;
                        out_data_d  = pend_q;
                        pend_d      = '0;
                        pend_cnt_d  = '0;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            num_rows_q  <= '0;
            skip_q      <= '0;
            row_len_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pend_q      <= '0;
            pend_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            fifo_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            num_rows_q  <= num_rows_d;
            skip_q      <= skip_d;
            row_len_q   <= row_len_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pend_q      <= pend_d;
            pend_cnt_q  <= pend_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    assign data_out  = out_data_q;
    assign valid_out = out_valid_q;

endmodule

// File: doc/align_compactor.md
Name: align_compactor

Overview:
- Stage directly downstream of the align stage.
- Receives raster-ordered groups of GROUP_SIZE items in which each output row is preceded by skip columns of invalid items, as produced by a negative Woff.
- Discards the skip columns and any trailing padding items.
- Repacks the kept items into dense GROUP_SIZE groups and zero-pads the final group.
- Feeds the write/output stage with the same valid/avail handshake.

Parameters:
GROUP_SIZE, 8, items per group (in and out)
DATA_WIDTH, 8, bits per item
LOG_MAX_COLS, 16, bits for skip/keep column counts
LOG_MAX_ROWS, 16, bits for row count

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
configure  in  1  CONFIGURE: one-cycle start pulse
num_rows  in  LOG_MAX_ROWS  CONFIGURE: rows to produce (>=1)
skip_cols  in  LOG_MAX_COLS  CONFIGURE: leading columns discarded per row
keep_cols  in  LOG_MAX_COLS  CONFIGURE: columns kept per row (>=1)
data_in  in  GROUP_SIZE*DATA_WIDTH  IN: group, lane 0 in LSBs
valid_in  in  1  IN: group valid
avail_out  out  1  IN: space available
data_out  out  GROUP_SIZE*DATA_WIDTH  OUT: packed group, lane 0 in LSBs
valid_out  out  1  OUT: one-cycle valid pulse
avail_in  in  1  OUT: consumer can accept this cycle

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE; FIFO empty; pending count 0; all counters 0.
  - valid_out=0, data_out=0.
  - avail_out is 1 once reset releases.
  - Reset mid-run abandons everything, including pending items.
- Input FIFO:
  - 4 slots, GROUP_SIZE*DATA_WIDTH wide.
  - Written every cycle valid_in=1.
  - avail_out = ~full & ~almost_full, combinational from FIFO flags.
  - Producer asserts valid_in only while avail_out=1.
- Configure:
  - Latches num_rows, skip_cols, keep_cols.
  - row_len = skip_cols + keep_cols, one bit wider than LOG_MAX_COLS.
  - Clears col_r, row_r and pending; goes to RUN.
  - configure during RUN/FLUSH restarts and discards pending items.
  - The FIFO is never flushed by configure.
  - Required: row_len >= GROUP_SIZE. Behaviour is undefined otherwise, since it guarantees at most one row wrap per group.
- States:
  - IDLE: no pops, valid_out=0.
  - RUN: pop = ~empty & avail_in. One group is consumed per pop.
  - FLUSH: entered when the last row completes and pending>0. Emits one group with the pending items in the low lanes and zero elsewhere when avail_in=1, then goes to IDLE.
  - If the last row completes with pending==0 after that cycle's emission, go straight to IDLE.
- Per-lane classification on pop, lane i = 0..GROUP_SIZE-1:
  - c = col_r + i; if c >= row_len then c -= row_len and r = row_r + 1, else r = row_r.
  - keep_i = (c >= skip_cols) & (r < num_rows).
  - After the pop: col_r = (col_r + GROUP_SIZE) mod row_len (single subtract); row_r += 1 if wrapped.
  - The last row is complete when row_r reaches num_rows, or when the group covers column row_len-1 of row num_rows-1. Remaining lanes of that group are discarded.
- Packing:
  - Kept lanes are compacted in ascending lane order and appended after the pending items (pending < GROUP_SIZE).
  - If pending + kept >= GROUP_SIZE, the first GROUP_SIZE items go out the same cycle as the pop: valid_out=1, data_out registered, 1-cycle latency from pop.
  - The remainder becomes pending.
  - At most one output group per pop, so popping only when avail_in=1 guarantees no output stall.
  - A group with zero kept lanes produces no output.
- valid_out is high for exactly one cycle per output group.
- data_out holds its last value when valid_out=0.
- The block never asserts valid_out with avail_in=0 on the pop/flush cycle.

Test Plan:
- Basic filtering:
  - Setup: GS=4, DW=8, skip=2, keep=3, rows=5; 7 input groups with item value = raster index 0..27; avail_in=1.
  - Output: exactly 4 groups, lane0 first: {2,3,4,7}, {8,9,12,13}, {14,17,18,19}, {22,23,24,0}.
  - Then IDLE; items 25..27 are discarded.
- Backpressure:
  - Same stimulus with avail_in toggling 1/0 every cycle.
  - Identical output sequence, no lost or duplicated group, valid_out only when avail_in=1.
  - avail_out drops when 3 groups are queued.
- Zero skip:
  - Setup: skip=0, keep=4, rows=2, GS=4; inputs {0,1,2,3}, {4,5,6,7}.
  - Outputs {0,1,2,3}, {4,5,6,7}; no FLUSH group.
- Flush padding:
  - Setup: skip=1, keep=4, rows=1; input {x,A,B,C}, {D,9,9,9}.
  - Outputs {A,B,C,D} only.
  - With keep=3 instead: output {A,B,C,0}.
- Reset mid-run:
  - Apply rst=0 after 3 input groups of the basic filtering setup.
  - valid_out=0, FIFO empty, avail_out=1.
  - After reconfigure and full stimulus: output matches basic filtering exactly.
- Reconfigure mid-run:
  - Pulse configure with pending=2 and an empty FIFO.
  - Pending items are never emitted; the new run's first output starts from the new stream.
